// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time keeper: parser states, BCD limits,
// and the BCD range check used when validating set-time frames.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_H,
    GET_M,
    GET_S
  } parse_state_t;

  localparam logic [7:0] HOUR_MAX          = 8'h23;
  localparam logic [7:0] MINSEC_MAX        = 8'h59;
  localparam logic [7:0] DEFAULT_FRAME_HDR = 8'hA5;

  // Once both nibbles are decimal digits, a plain binary compare orders BCD correctly.
  function automatic logic is_bcd_le(input logic [7:0] bcd_byte, input logic [7:0] max);
    return (bcd_byte[7:4] <= 4'd9) && (bcd_byte[3:0] <= 4'd9) && (bcd_byte <= max);
  endfunction

endpackage

// File: rtl/rtc_bcd_pair.sv
// Two-digit BCD modulo counter with a parallel load; carry flags the wrap
// so that several pairs can be chained.
module rtc_bcd_pair
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX = MINSEC_MAX
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (value == MAX) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/rtc_time_keeper.sv
// 24-hour BCD time-of-day keeper with a per-second update flag and a
// UART-fed set-time frame parser (header, hour, minute, second).
module rtc_time_keeper
  import rtc_pkg::*;
#(
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         FRAME_TIMEOUT = 500_000,
  parameter logic [7:0] FRAME_HDR     = DEFAULT_FRAME_HDR
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Seconds,
  output logic       uart_tx_flag,
  output logic       set_err
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int TW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ - 1);
  localparam logic [TW-1:0] TO_TC  = TW'(FRAME_TIMEOUT - 1);

  logic [PW-1:0] prescaler;
  logic [TW-1:0] timeout_cnt;
  parse_state_t  state;
  logic [7:0]    shadow_h;
  logic [7:0]    shadow_m;
  logic          tick;
  logic          frame_load;
  logic          sec_carry;
  logic          min_carry;
  logic          hour_carry;

  assign tick       = (prescaler == PRE_TC);
  assign frame_load = rx_done && (state == GET_S) && is_bcd_le(rx_data, MINSEC_MAX);

  // A frame load restarts the second so the loaded time is held for a full second.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prescaler    <= '0;
      uart_tx_flag <= 1'b0;
    end else begin
      uart_tx_flag <= frame_load || tick;
      if (frame_load || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      shadow_h    <= 8'h00;
      shadow_m    <= 8'h00;
      timeout_cnt <= '0;
      set_err     <= 1'b0;
    end else begin
      set_err <= 1'b0;
      if (rx_done) begin
        timeout_cnt <= '0;
        case (state)
          IDLE: begin
            if (rx_data == FRAME_HDR) state <= GET_H;
          end
          GET_H: begin
            if (is_bcd_le(rx_data, HOUR_MAX)) begin
              shadow_h <= rx_data;
              state    <= GET_M;
            end else begin
              state   <= IDLE;
              set_err <= 1'b1;
            end
          end
          GET_M: begin
            if (is_bcd_le(rx_data, MINSEC_MAX)) begin
              shadow_m <= rx_data;
              state    <= GET_S;
            end else begin
              state   <= IDLE;
              set_err <= 1'b1;
            end
          end
          GET_S: begin
            state <= IDLE;
            if (!is_bcd_le(rx_data, MINSEC_MAX)) set_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timeout_cnt == TO_TC) begin
          state       <= IDLE;
          set_err     <= 1'b1;
          timeout_cnt <= '0;
          shadow_h    <= 8'h00;
          shadow_m    <= 8'h00;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
      end else begin
        timeout_cnt <= '0;
      end
    end
  end

  // A load suppresses the tick so only the loaded value appears, with one flag.
  rtc_bcd_pair #(.MAX(MINSEC_MAX)) u_seconds (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (tick && !frame_load),
    .load     (frame_load),
    .load_val (rx_data),
    .value    (Seconds),
    .carry    (sec_carry)
  );

  rtc_bcd_pair #(.MAX(MINSEC_MAX)) u_minute (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (sec_carry),
    .load     (frame_load),
    .load_val (shadow_m),
    .value    (Minute),
    .carry    (min_carry)
  );

  rtc_bcd_pair #(.MAX(HOUR_MAX)) u_hour (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (min_carry),
    .load     (frame_load),
    .load_val (shadow_h),
    .value    (Hour),
    .carry    (hour_carry)
  );

  logic unused_carry;
  assign unused_carry = hour_carry;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Self-checking bench for rtc_time_keeper: directed scenarios plus random frames,
// compared every cycle against a seconds-of-day reference model.
module tb_rtc_time_keeper;

  localparam int         CLK_FREQ      = 10;
  localparam int         FRAME_TIMEOUT = 20;
  localparam logic [7:0] HDR           = 8'hA5;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] Hour;
  logic [7:0] Minute;
  logic [7:0] Seconds;
  logic       uart_tx_flag;
  logic       set_err;

  int error_count = 0;
  int check_count = 0;

  // Reference model: time as seconds since midnight, frame progress as a byte index.
  int m_sec = 0;
  int m_pre = 0;
  int m_idx = 0;
  int m_toc = 0;
  int m_sh  = 0;
  int m_sm  = 0;

  rtc_time_keeper #(
    .CLK_FREQ      (CLK_FREQ),
    .FRAME_TIMEOUT (FRAME_TIMEOUT),
    .FRAME_HDR     (HDR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .Hour         (Hour),
    .Minute       (Minute),
    .Seconds      (Seconds),
    .uart_tx_flag (uart_tx_flag),
    .set_err      (set_err)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [23:0] model_time();
    return {int_to_bcd(m_sec / 3600), int_to_bcd((m_sec / 60) % 60), int_to_bcd(m_sec % 60)};
  endfunction

  task automatic applyStimulus(input logic rst, input logic done, input logic [7:0] data);
    logic exp_flag;
    logic exp_err;
    logic tick;
    logic load;
    int   v;
    Reset    = rst;
    rx_done  = done;
    rx_data  = data;
    exp_flag = 1'b0;
    exp_err  = 1'b0;
    load     = 1'b0;
    v        = 0;
    if (rst) begin
      m_sec = 0; m_pre = 0; m_idx = 0; m_toc = 0; m_sh = 0; m_sm = 0;
    end else begin
      tick = (m_pre == CLK_FREQ - 1);
      if (done) begin
        m_toc = 0;
        v = bcd_to_int(data);
        case (m_idx)
          0: if (data == HDR) m_idx = 1;
          1: if (v >= 0 && v <= 23) begin m_sh = v; m_idx = 2; end
             else begin exp_err = 1'b1; m_idx = 0; end
          2: if (v >= 0 && v <= 59) begin m_sm = v; m_idx = 3; end
             else begin exp_err = 1'b1; m_idx = 0; end
          default: begin
            if (v >= 0 && v <= 59) load = 1'b1;
            else exp_err = 1'b1;
            m_idx = 0;
          end
        endcase
      end else if (m_idx != 0) begin
        if (m_toc == FRAME_TIMEOUT - 1) begin
          exp_err = 1'b1; m_idx = 0; m_toc = 0;
        end else begin
          m_toc++;
        end
      end
      if (load) begin
        m_sec = m_sh * 3600 + m_sm * 60 + v; m_pre = 0; exp_flag = 1'b1;
      end else if (tick) begin
        m_sec = (m_sec + 1) % 86400; m_pre = 0; exp_flag = 1'b1;
      end else begin
        m_pre++;
      end
    end
    @(posedge Clk);
    #1;
    checkOutput("time", {8'h00, Hour, Minute, Seconds}, {8'h00, model_time()});
    checkOutput("uart_tx_flag", 32'(uart_tx_flag), 32'(exp_flag));
    checkOutput("set_err", 32'(set_err), 32'(exp_err));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, b);
    idle();
  endtask

  initial begin
    int r;
    logic [7:0] b;

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reset_time", {8'h00, Hour, Minute, Seconds}, 32'h0);

    repeat (35) idle();
    checkOutput("run35_time", {8'h00, Hour, Minute, Seconds}, 32'h0000_0003);

    sendByte(HDR); sendByte(8'h23); sendByte(8'h59); sendByte(8'h58);
    repeat (20) idle();
    checkOutput("midnight_wrap", {8'h00, Hour, Minute, Seconds}, 32'h0000_0000);

    sendByte(HDR); sendByte(8'h24); sendByte(8'h00); sendByte(8'h00);
    sendByte(HDR); sendByte(8'h12); sendByte(8'h34);
    applyStimulus(1'b0, 1'b1, 8'h56);
    checkOutput("load_123456", {8'h00, Hour, Minute, Seconds}, 32'h0012_3456);
    idle();

    sendByte(HDR); sendByte(8'h12); sendByte(8'h5A);
    sendByte(HDR); applyStimulus(1'b0, 1'b1, 8'h12);
    repeat (22) idle();

    sendByte(HDR); sendByte(8'h07); sendByte(8'h08);
    while (m_pre != CLK_FREQ - 1) idle();
    applyStimulus(1'b0, 1'b1, 8'h09);
    checkOutput("coincident_load", {8'h00, Hour, Minute, Seconds}, 32'h0007_0809);
    checkOutput("coincident_flag", 32'(uart_tx_flag), 32'd1);
    repeat (CLK_FREQ - 1) idle();
    checkOutput("prescaler_cleared", 32'(Seconds), 32'h09);
    idle();
    checkOutput("first_tick_after_load", 32'(Seconds), 32'h10);

    sendByte(8'h00); sendByte(8'hFF);

    sendByte(HDR); sendByte(8'h12);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("midframe_reset", {8'h00, Hour, Minute, Seconds}, 32'h0);
    sendByte(8'h34); sendByte(8'h56);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        applyStimulus(1'b1, 1'b0, 8'h00);
      end else if (r < 5) begin
        repeat (FRAME_TIMEOUT + 2) idle();
      end else if (r < 50) begin
        idle();
      end else begin
        if (m_idx == 0 && $urandom_range(0, 1) == 1) b = HDR;
        else if ($urandom_range(0, 3) == 0) b = 8'($urandom);
        else b = int_to_bcd(int'($urandom_range(0, (m_idx == 1) ? 25 : 61)));
        applyStimulus(1'b0, 1'b1, b);
      end
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
